timer_scheduler: RTL and testbench

TIMER_SCHEDULER -- requirements
Module: timer_scheduler

---
 rtl/timer_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_timer_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_scheduler.sv
// timer_scheduler: round-robin sharing of one interval timer among
// NREQ requesters, driving the timer through a write-only master.
module timer_scheduler #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_cycles,
  input  logic [NREQ-1:0]      cancel,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      aborted,
  output logic                 busy,
  output logic [2:0]           active_id,
  output logic [2:0]           tm_address,
  output logic                 tm_chipselect,
  output logic                 tm_write_n,
  output logic [15:0]          tm_writedata,
  input  logic                 tm_irq
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_WPL,
    S_WPH,
    S_GAP,
    S_WCTL,
    S_WAIT,
    S_STOP,
    S_ACK,
    S_FIN
  } state_e;

  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_CTRL   = 3'd1;
  localparam logic [2:0] A_PERL   = 3'd2;
  localparam logic [2:0] A_PERH   = 3'd3;

  localparam logic [15:0] CTRL_GO   = 16'h0005;
  localparam logic [15:0] CTRL_STOP = 16'h0008;

  state_e      state_q, state_d;
  logic [2:0]  active_q, active_d;
  logic [2:0]  last_q, last_d;
  logic [31:0] load_q, load_d;
  logic        irq_exit_q, irq_exit_d;

  logic        lo_vld, hi_vld, gnt_vld;
  logic [2:0]  lo_id, hi_id, gnt_id;
  logic [31:0] gnt_cyc;
  logic        stop_req;

  // Round-robin pick: lowest requester above last_q, else lowest overall
  always_comb begin
    lo_vld = 1'b0;
    hi_vld = 1'b0;
    lo_id  = '0;
    hi_id  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_vld = 1'b1;
        lo_id  = 3'(i);
      end
      if (req[i] && (3'(i) > last_q)) begin
        hi_vld = 1'b1;
        hi_id  = 3'(i);
      end
    end
    gnt_vld = lo_vld;
    gnt_id  = hi_vld ? hi_id : lo_id;
  end

  // Delay slice of the winner and abort condition of the active job
  always_comb begin
    gnt_cyc  = '0;
    stop_req = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == 3'(i)) begin
        gnt_cyc = req_cycles[32*i +: 32];
      end
      if (active_q == 3'(i)) begin
        stop_req = cancel[i] | ~req[i];
      end
    end
  end

  // State and job registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      active_q   <= '0;
      last_q     <= 3'(NREQ - 1);
      load_q     <= '0;
      irq_exit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      last_q     <= last_d;
      load_q     <= load_d;
      irq_exit_q <= irq_exit_d;
    end
  end

  // Next-state and job bookkeeping
  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    last_d     = last_q;
    load_d     = load_q;
    irq_exit_d = irq_exit_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          state_d  = S_CLR;
          active_d = gnt_id;
          load_d   = (gnt_cyc == 32'd0) ? 32'd0
                                        : gnt_cyc - 32'd1;
        end
      end
      S_CLR:  state_d = S_WPL;
      S_WPL:  state_d = S_WPH;
      S_WPH:  state_d = S_GAP;
      S_GAP:  state_d = S_WCTL;
      S_WCTL: state_d = S_WAIT;
      S_WAIT: begin
        if (tm_irq) begin
          state_d    = S_ACK;
          irq_exit_d = 1'b1;
        end else if (stop_req) begin
          state_d    = S_STOP;
          irq_exit_d = 1'b0;
        end
      end
      S_STOP: state_d = S_ACK;
      S_ACK:  state_d = S_FIN;
      S_FIN: begin
        state_d = S_IDLE;
        last_d  = active_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Timer bus writes and status pulses decoded from state
  always_comb begin
    tm_chipselect = 1'b0;
    tm_write_n    = 1'b1;
    tm_address    = '0;
    tm_writedata  = '0;
    done          = '0;
    aborted       = '0;
    busy          = (state_q != S_IDLE);
    active_id     = active_q;
    unique case (state_q)
      S_CLR: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = A_STATUS;
      end
      S_WPL: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = A_PERL;
        tm_writedata  = load_q[15:0];
      end
      S_WPH: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = A_PERH;
        tm_writedata  = load_q[31:16];
      end
      S_WCTL: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = A_CTRL;
        tm_writedata  = CTRL_GO;
      end
      S_STOP: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = A_CTRL;
        tm_writedata  = CTRL_STOP;
      end
      S_ACK: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = A_STATUS;
      end
      S_FIN: begin
        for (int i = 0; i < NREQ; i++) begin
          if (active_q == 3'(i)) begin
            done[i]    = irq_exit_q;
            aborted[i] = ~irq_exit_q;
          end
        end
      end
      default: begin
        tm_chipselect = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// tb_timer_scheduler: vector table plus scoreboard of expected
// timer writes for timer_scheduler.
module tb_timer_scheduler;
  localparam int NREQ = 4;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NREQ-1:0]     req;
  logic [32*NREQ-1:0]  req_cycles;
  logic [NREQ-1:0]     cancel;
  logic [NREQ-1:0]     done;
  logic [NREQ-1:0]     aborted;
  logic                busy;
  logic [2:0]          active_id;
  logic [2:0]          tm_address;
  logic                tm_chipselect;
  logic                tm_write_n;
  logic [15:0]         tm_writedata;
  logic                tm_irq;

  timer_scheduler #(.NREQ(NREQ)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .req_cycles    (req_cycles),
    .cancel        (cancel),
    .done          (done),
    .aborted       (aborted),
    .busy          (busy),
    .active_id     (active_id),
    .tm_address    (tm_address),
    .tm_chipselect (tm_chipselect),
    .tm_write_n    (tm_write_n),
    .tm_writedata  (tm_writedata),
    .tm_irq        (tm_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic [3:0]  add;
    logic [31:0] cyc;
    int          id;
    logic [15:0] pl;
    logic [15:0] ph;
    int          mode;
    int          dwell;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  e;
  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   wctl_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && tm_chipselect === 1'b1 &&
        tm_write_n === 1'b0) begin
      if (tm_address == 3'd1 && tm_writedata == 16'h0005)
        wctl_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h expected none",
                 tm_address, tm_writedata);
      end else begin
        e = exp_q.pop_front();
        check("write", {13'd0, tm_address, tm_writedata},
              {13'd0, e.a, e.d});
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_start(input logic [15:0] pl, input logic [15:0] ph);
    exp_q.push_back('{3'd0, 16'h0000});
    exp_q.push_back('{3'd2, pl});
    exp_q.push_back('{3'd3, ph});
    exp_q.push_back('{3'd1, 16'h0005});
  endtask

  task automatic wait_wctl();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (wctl_cyc >= 0) seen = 1'b1;
    end
  endtask

  // mode: 0 irq, 1 cancel, 2 irq+cancel together, 3 req dropped
  task automatic do_job(input int id, input logic [15:0] pl,
                        input logic [15:0] ph, input int mode,
                        input int dwell);
    int t0;
    logic [3:0] oh;
    logic [3:0] exp_done;
    oh = 4'(1 << id);
    t0 = cyc;
    wctl_cyc = -1;
    push_start(pl, ph);
    wait_wctl();
    check("start_latency", wctl_cyc - t0, 5);
    check("active_id", {29'd0, active_id}, id);
    check("busy_job", {31'd0, busy}, 1);
    repeat (dwell) step();
    case (mode)
      0: begin
        tm_irq = 1'b1;
        exp_q.push_back('{3'd0, 16'h0000});
        step();
        tm_irq = 1'b0;
        step();
      end
      2: begin
        tm_irq = 1'b1;
        cancel[id] = 1'b1;
        exp_q.push_back('{3'd0, 16'h0000});
        step();
        tm_irq = 1'b0;
        cancel[id] = 1'b0;
        step();
      end
      default: begin
        if (mode == 1) cancel[id] = 1'b1;
        else req[id] = 1'b0;
        exp_q.push_back('{3'd1, 16'h0008});
        exp_q.push_back('{3'd0, 16'h0000});
        step();
        cancel[id] = 1'b0;
        step();
        step();
      end
    endcase
    exp_done = (mode == 0 || mode == 2) ? oh : 4'b0;
    check("done_fin", {28'd0, done}, {28'd0, exp_done});
    check("aborted_fin", {28'd0, aborted},
          {28'd0, (exp_done == 4'b0) ? oh : 4'b0});
    req[id] = 1'b0;
    step();
    check("done_idle", {28'd0, done}, 0);
    check("aborted_idle", {28'd0, aborted}, 0);
    check("busy_idle", {31'd0, busy}, 0);
    check("writes_left", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_active_id", {29'd0, active_id}, 0);
    check("rst_cs", {31'd0, tm_chipselect}, 0);
    check("rst_write_n", {31'd0, tm_write_n}, 1);
    check("rst_addr", {29'd0, tm_address}, 0);
    check("rst_data", {16'd0, tm_writedata}, 0);
    check("rst_done", {28'd0, done}, 0);
    check("rst_aborted", {28'd0, aborted}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b0001, 32'd100,        0, 16'h0063, 16'h0000, 0, 95};
    vecs[1] = '{4'b1010, 32'h0000_0200,  1, 16'h01FF, 16'h0000, 0, 5};
    vecs[2] = '{4'b0000, 32'h0,          3, 16'h01FF, 16'h0000, 0, 3};
    vecs[3] = '{4'b1011, 32'h0001_0000,  0, 16'hFFFF, 16'h0000, 0, 4};
    vecs[4] = '{4'b0000, 32'h0,          1, 16'hFFFF, 16'h0000, 1, 10};
    vecs[5] = '{4'b0000, 32'h0,          3, 16'hFFFF, 16'h0000, 2, 6};
    vecs[6] = '{4'b0100, 32'd0,          2, 16'h0000, 16'h0000, 1, 10};
    vecs[7] = '{4'b0100, 32'd1,          2, 16'h0000, 16'h0000, 0, 2};
    vecs[8] = '{4'b0001, 32'hABCD_1235,  0, 16'h1234, 16'hABCD, 3, 7};
    vecs[9] = '{4'b0010, 32'hFFFF_FFFF,  1, 16'hFFFE, 16'hFFFF, 0, 1};

    reset_n    = 1'b0;
    req        = '0;
    req_cycles = '0;
    cancel     = '0;
    tm_irq     = 1'b0;
    step();
    step();
    check_reset_outputs();
    reset_n = 1'b1;
    step();

    for (int v = 0; v < 10; v++) begin
      for (int b = 0; b < NREQ; b++) begin
        if (vecs[v].add[b]) req_cycles[32*b +: 32] = vecs[v].cyc;
      end
      req = req | vecs[v].add;
      do_job(vecs[v].id, vecs[v].pl, vecs[v].ph,
             vecs[v].mode, vecs[v].dwell);
    end

    req_cycles[64 +: 32] = 32'd50;
    req[2] = 1'b1;
    wctl_cyc = -1;
    push_start(16'd49, 16'd0);
    wait_wctl();
    check("rst_job_started", {31'd0, (wctl_cyc >= 0)}, 1);
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    req = 4'b0101;
    req_cycles[0 +: 32]  = 32'd7;
    req_cycles[64 +: 32] = 32'd9;
    step();
    step();
    check("busy_in_reset", {31'd0, busy}, 0);
    reset_n = 1'b1;
    do_job(0, 16'd6, 16'd0, 0, 2);
    do_job(2, 16'd8, 16'd0, 0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
